id_ctrl_seq_unit: RTL and testbench
===================================

Name: id_ctrl_seq_unit

Overview:
Registered successor to the combinational ID-stage control decoder. Decodes op_code/mode/S into execute/memory/writeback controls and presents them through a valid/ready output register feeding the ID/EX pipeline. Adds hazard bubble insertion, synchronous flush, and a multi-beat block-transfer mode (mode 2'b11) sequenced by an internal FSM. Exe-command width and maximum burst length are parametrised.

Parameters:
EXE_CMD_W, 4, width of exe_cmd; encodings zero-extended from 4-bit package constants.
BURST_MAX, 4, maximum beats per block transfer (>=1).
BEAT_W, 3, width of burst_len and beat_idx; must satisfy 2**BEAT_W > BURST_MAX.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction fields valid
in_ready  out  1  unit accepts instruction this cycle
s_in  in  1  S bit (also L/S select for mode 01)
op_code  in  4  data-processing opcode
mode  in  2  00 DP-reg, 01 mem, 10 branch, 11 block transfer
burst_len  in  BEAT_W  beats for mode 11
hazard  in  1  stall request from hazard unit
flush  in  1  branch-taken flush
out_valid  out  1  control bundle valid
out_ready  in  1  ID/EX register can take bundle
s_out, b, mem_r_en, mem_w_en, wb_en  out  1 each  registered controls
exe_cmd  out  EXE_CMD_W  ALU command
beat_idx  out  BEAT_W  current beat (0 for non-burst)
last_beat  out  1  final beat of the instruction (1 for non-burst)

Behaviour:
- Reset (rst_n=0, async): out_valid=0, all controls 0, exe_cmd=0, beat_idx=0, last_beat=0, state IDLE.
- Decode table (mode != 10): 1101 MOV cmd 0001 wb; 1111 MVN 1001 wb; 0100 ADD 0010 (mode 00 wb; mode 01 & s_in=1 LDR: wb+mem_r; mode 01 & s_in=0 STR: mem_w only); 0101 ADC 0011 wb; 0010 SUB 0100 wb; 0110 SBC 0101 wb; 0000 AND 0110 wb; 1100 ORR 0111 wb; 0001 EOR 1000 wb; 1010 CMP 0100 no wb; 1000 TST 0110 no wb; other opcodes: all 0. s_out=s_in except mem/block modes, where s_out=0.
- mode 10: b=op_code[3]==0; all other controls 0.
- mode 11: exe_cmd ADD; op_code[0]=1 load multiple (mem_r_en+wb_en), 0 store multiple (mem_w_en). Effective length N = max(1, min(burst_len, BURST_MAX)).
- Advance condition adv = !out_valid || out_ready.
- in_ready = (state==IDLE) && !hazard && !flush && adv (combinational).
- Accept (in_valid && in_ready): bundle loaded next edge, out_valid=1, 1-cycle latency. Non-burst: beat_idx=0, last_beat=1. Burst: beat 0, last_beat=(N==1); if N>1 go BURST with remaining=N-1.
- BURST: on adv && !hazard, emit beat_idx+1, last_beat when beat_idx+1==N-1; after last beat emitted return IDLE. No new instruction accepted while in BURST.
- Hazard with adv true and no accept: bubble inserted — out_valid=0, all controls and exe_cmd forced 0; burst position held.
- Not adv (out_valid && !out_ready): all outputs hold, independent of hazard.
- flush (highest priority, synchronous): out_valid=0, controls 0, beat_idx=0, state IDLE, burst aborted; same-cycle in_valid ignored.
- Idle with no accept and adv: out_valid=0, controls 0.

Optional Feature:
ID_CTRL_STATS_EN: defined adds outputs stat_issue_cnt[15:0] (increments per emitted beat/bundle, out_valid&&out_ready) and stat_bubble_cnt[15:0] (increments per hazard bubble); wrap modulo 2^16, reset 0, not cleared by flush. Undefined: ports and counters absent, behaviour otherwise identical.

Decomposition:
Package id_ctrl_pkg: opcode constants, mode constants, 4-bit exe_cmd encodings, FSM state enum (IDLE, BURST). One combinational sub-module id_ctrl_decode (table above, mode 11 included); top holds FSM, counters, output register.

Test Plan:
- Reset mid-burst: mode 11 burst_len=3 accepted, assert rst_n=0 after beat 1 -> all outputs 0 immediately, state IDLE.
- LDR: mode 01 op 0100 s_in=1, out_ready=1 -> next cycle out_valid=1, exe_cmd=0010, wb_en=1, mem_r_en=1, mem_w_en=0, s_out=0, last_beat=1.
- Backpressure: SUB accepted, out_ready=0 for 3 cycles -> bundle held (exe_cmd=0100, wb_en=1), in_ready=0; then released -> next instruction accepted.
- Hazard bubble: hazard=1 one cycle with in_valid=1 -> in_ready=0, out_valid=0 with all controls 0; instruction accepted the following cycle.
- Block store burst_len=6 (BURST_MAX=4) -> exactly 4 beats beat_idx 0..3, mem_w_en=1, last_beat only on beat 3, in_ready=0 throughout.
- Flush during burst beat 1 -> next cycle out_valid=0, beat_idx=0, in_ready=1; branch mode 10 op 0101 then yields b=1.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
// Shared encodings for the ID-stage control sequencer: opcodes, modes,
// ALU command codes, the control bundle and the FSM state type.
package id_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_BLK = 2'b11;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic       s;
    logic       b;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic [3:0] cmd;
  } ctrl_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational op_code/mode/S decoder producing the raw control bundle.
module id_ctrl_decode
  import id_ctrl_pkg::*;
(
  input  logic       s_in,
  input  logic [3:0] op_code,
  input  logic [1:0] mode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_BR: ctrl.b = ~op_code[3];
      MODE_BLK: begin
        ctrl.cmd = CMD_ADD;
        if (op_code[0]) begin
          ctrl.mem_r = 1'b1;
          ctrl.wb    = 1'b1;
        end else begin
          ctrl.mem_w = 1'b1;
        end
      end
      default: begin
        ctrl.s  = (mode == MODE_DP) ? s_in : 1'b0;
        ctrl.wb = 1'b1;
        case (op_code)
          OP_MOV: ctrl.cmd = CMD_MOV;
          OP_MVN: ctrl.cmd = CMD_MVN;
          OP_ADD: begin
            ctrl.cmd = CMD_ADD;
            // In memory mode ADD forms the address: S selects load vs store
            if (mode == MODE_MEM) begin
              ctrl.wb    = s_in;
              ctrl.mem_r = s_in;
              ctrl.mem_w = ~s_in;
            end
          end
          OP_ADC: ctrl.cmd = CMD_ADC;
          OP_SUB: ctrl.cmd = CMD_SUB;
          OP_SBC: ctrl.cmd = CMD_SBC;
          OP_AND: ctrl.cmd = CMD_AND;
          OP_ORR: ctrl.cmd = CMD_ORR;
          OP_EOR: ctrl.cmd = CMD_EOR;
          OP_CMP: begin
            ctrl.cmd = CMD_SUB;
            ctrl.wb  = 1'b0;
          end
          OP_TST: begin
            ctrl.cmd = CMD_AND;
            ctrl.wb  = 1'b0;
          end
          default: ctrl = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ctrl_seq_unit.sv
// Registered ID-stage control unit with bubble insertion, flush and block-transfer
// sequencing. Define ID_CTRL_STATS_EN to add issue/bubble statistics counters.
module id_ctrl_seq_unit
  import id_ctrl_pkg::*;
#(
  parameter int EXE_CMD_W = 4,
  parameter int BURST_MAX = 4,
  parameter int BEAT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 s_in,
  input  logic [3:0]           op_code,
  input  logic [1:0]           mode,
  input  logic [BEAT_W-1:0]    burst_len,
  input  logic                 hazard,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 s_out,
  output logic                 b,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 wb_en,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic [BEAT_W-1:0]    beat_idx,
  output logic                 last_beat
`ifdef ID_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_issue_cnt,
  output logic [15:0]          stat_bubble_cnt
`endif
);

  state_t             state;
  ctrl_t              dec, ctrl_q, bctrl_q;
  logic [BEAT_W-1:0]  n_eff, n_q, nxt_beat;
  logic               adv, accept, bubble;

  id_ctrl_decode u_dec (
    .s_in    (s_in),
    .op_code (op_code),
    .mode    (mode),
    .ctrl    (dec)
  );

  assign adv      = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && !hazard && !flush && adv;
  assign accept   = in_valid && in_ready;
  assign bubble   = adv && hazard && !flush;
  assign nxt_beat = beat_idx + BEAT_W'(1);

  always_comb begin
    n_eff = burst_len;
    if (burst_len == '0)                     n_eff = BEAT_W'(1);
    else if (burst_len > BEAT_W'(BURST_MAX)) n_eff = BEAT_W'(BURST_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      bctrl_q   <= '0;
      n_q       <= '0;
      beat_idx  <= '0;
      last_beat <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      beat_idx  <= '0;
      last_beat <= 1'b0;
    end else if (adv) begin
      if (state == BURST) begin
        if (hazard) begin
          // Bubble mid-burst: beat_idx keeps the burst position
          out_valid <= 1'b0;
          ctrl_q    <= '0;
          last_beat <= 1'b0;
        end else begin
          out_valid <= 1'b1;
          ctrl_q    <= bctrl_q;
          beat_idx  <= nxt_beat;
          last_beat <= (nxt_beat == n_q - BEAT_W'(1));
          if (nxt_beat == n_q - BEAT_W'(1)) state <= IDLE;
        end
      end else if (accept) begin
        out_valid <= 1'b1;
        ctrl_q    <= dec;
        beat_idx  <= '0;
        if (mode == MODE_BLK) begin
          bctrl_q   <= dec;
          n_q       <= n_eff;
          last_beat <= (n_eff == BEAT_W'(1));
          if (n_eff != BEAT_W'(1)) state <= BURST;
        end else begin
          last_beat <= 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
        ctrl_q    <= '0;
        beat_idx  <= '0;
        last_beat <= 1'b0;
      end
    end
  end

  assign s_out    = ctrl_q.s;
  assign b        = ctrl_q.b;
  assign mem_r_en = ctrl_q.mem_r;
  assign mem_w_en = ctrl_q.mem_w;
  assign wb_en    = ctrl_q.wb;
  assign exe_cmd  = EXE_CMD_W'(ctrl_q.cmd);

`ifdef ID_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue_cnt  <= '0;
      stat_bubble_cnt <= '0;
    end else begin
      if (out_valid && out_ready) stat_issue_cnt <= stat_issue_cnt + 16'd1;
      if (bubble)                 stat_bubble_cnt <= stat_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ctrl_seq_unit.sv
// Scoreboard bench for id_ctrl_seq_unit: expected bundles queued at issue,
// popped when the DUT hands a bundle to the ID/EX register.
module tb_id_ctrl_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, s_in, hazard, flush, out_ready;
  logic [3:0] op_code;
  logic [1:0] mode;
  logic [2:0] burst_len;
  logic       in_ready, out_valid, s_out, b, mem_r_en, mem_w_en, wb_en, last_beat;
  logic [3:0] exe_cmd;
  logic [2:0] beat_idx;

  int n_chk = 0;
  int n_err = 0;
  logic [12:0] sb_q[$];
  logic [12:0] sb_e;
  logic [12:0] bundle;

  id_ctrl_seq_unit #(.EXE_CMD_W(4), .BURST_MAX(4), .BEAT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .op_code(op_code), .mode(mode), .burst_len(burst_len),
    .hazard(hazard), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .s_out(s_out), .b(b), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
    .exe_cmd(exe_cmd), .beat_idx(beat_idx), .last_beat(last_beat)
  );

  always #5 clk = ~clk;

  assign bundle = {exe_cmd, s_out, b, mem_r_en, mem_w_en, wb_en, beat_idx, last_beat};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // bundle layout: {cmd[3:0], s,b,mem_r,mem_w,wb, beat[2:0], last}
  function automatic logic [12:0] mk(input logic [3:0] cmd, input logic [4:0] fl,
                                     input logic [2:0] bt, input logic lst);
    return {cmd, fl, bt, lst};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] md, input logic [3:0] op, input logic s,
                       input logic [2:0] len, input string tag);
    in_valid = 1'b1; mode = md; op_code = op; s_in = s; burst_len = len;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic dec(input logic [1:0] md, input logic [3:0] op, input logic s,
                     input logic [3:0] cmd, input logic [4:0] fl, input string tag);
    sb_q.push_back(mk(cmd, fl, 3'd0, 1'b1));
    issue(md, op, s, 3'd0, tag);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected", sb_q.size(), 1);
      else begin
        sb_e = sb_q.pop_front();
        chk("sb_beat", bundle, sb_e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; s_in = 1'b0; op_code = 4'd0; mode = 2'd0;
    burst_len = 3'd0; hazard = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_bundle", bundle, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // decode table, back-to-back
    dec(2'b01, 4'b0100, 1'b1, 4'b0010, 5'b00101, "ldr");
    dec(2'b01, 4'b0100, 1'b0, 4'b0010, 5'b00010, "str");
    dec(2'b00, 4'b1101, 1'b1, 4'b0001, 5'b10001, "mov");
    dec(2'b00, 4'b1111, 1'b0, 4'b1001, 5'b00001, "mvn");
    dec(2'b00, 4'b0101, 1'b1, 4'b0011, 5'b10001, "adc");
    dec(2'b00, 4'b0110, 1'b0, 4'b0101, 5'b00001, "sbc");
    dec(2'b00, 4'b0000, 1'b0, 4'b0110, 5'b00001, "and");
    dec(2'b00, 4'b1100, 1'b1, 4'b0111, 5'b10001, "orr");
    dec(2'b00, 4'b0001, 1'b0, 4'b1000, 5'b00001, "eor");
    dec(2'b00, 4'b1010, 1'b1, 4'b0100, 5'b10000, "cmp");
    dec(2'b00, 4'b1000, 1'b0, 4'b0110, 5'b00000, "tst");
    dec(2'b00, 4'b0011, 1'b0, 4'b0000, 5'b00000, "undef");
    tick();
    chk("idle_vld", out_valid, 0);

    // backpressure: SUB held for 3 cycles, ADD waits
    dec(2'b00, 4'b0010, 1'b0, 4'b0100, 5'b00001, "sub");
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 2'b00; op_code = 4'b0100; s_in = 1'b0;
    #1;
    chk("bp_rdy", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_vld", out_valid, 1);
      chk("bp_bundle", bundle, mk(4'b0100, 5'b00001, 3'd0, 1'b1));
      chk("bp_rdy_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    sb_q.push_back(mk(4'b0010, 5'b00001, 3'd0, 1'b1));
    #1;
    chk("bp_release_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;

    // hazard bubble then accept
    in_valid = 1'b1; mode = 2'b00; op_code = 4'b1101; s_in = 1'b0; hazard = 1'b1;
    #1;
    chk("hz_rdy", in_ready, 0);
    tick();
    chk("hz_vld", out_valid, 0);
    chk("hz_bundle", bundle, 0);
    hazard = 1'b0;
    dec(2'b00, 4'b1101, 1'b0, 4'b0001, 5'b00001, "hz_mov");

    // block store, length clamped to BURST_MAX
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(4'b0010, 5'b00010, 3'(i), i == 3));
    issue(2'b11, 4'b0000, 1'b1, 3'd6, "stm");
    in_valid = 1'b1; mode = 2'b00; op_code = 4'b1101; s_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stm_busy", in_ready, 0);
      tick();
    end
    #1;
    chk("stm_done_rdy", in_ready, 1);
    sb_q.push_back(mk(4'b0001, 5'b00001, 3'd0, 1'b1));
    tick();
    in_valid = 1'b0;
    tick();
    chk("stm_idle_vld", out_valid, 0);

    // block load of 2, then length 0 acts as a single beat
    sb_q.push_back(mk(4'b0010, 5'b00101, 3'd0, 1'b0));
    sb_q.push_back(mk(4'b0010, 5'b00101, 3'd1, 1'b1));
    issue(2'b11, 4'b0001, 1'b0, 3'd2, "ldm2");
    tick();
    tick();
    chk("ldm2_idle_vld", out_valid, 0);
    sb_q.push_back(mk(4'b0010, 5'b00101, 3'd0, 1'b1));
    issue(2'b11, 4'b0001, 1'b0, 3'd0, "ldm0");
    #1;
    chk("ldm0_rdy", in_ready, 1);

    // flush during beat 1 of a 4-beat load
    sb_q.push_back(mk(4'b0010, 5'b00101, 3'd0, 1'b0));
    sb_q.push_back(mk(4'b0010, 5'b00101, 3'd1, 1'b0));
    issue(2'b11, 4'b0001, 1'b0, 3'd4, "ldm4");
    tick();
    flush = 1'b1;
    in_valid = 1'b1; mode = 2'b00; op_code = 4'b1101; s_in = 1'b1;
    #1;
    chk("fl_rdy", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_vld", out_valid, 0);
    chk("fl_beat", beat_idx, 0);
    chk("fl_rdy_after", in_ready, 1);
    dec(2'b10, 4'b0101, 1'b1, 4'b0000, 5'b01000, "br_taken");
    dec(2'b10, 4'b1010, 1'b1, 4'b0000, 5'b00000, "br_not");

    // async reset in the middle of a 3-beat store
    sb_q.push_back(mk(4'b0010, 5'b00010, 3'd0, 1'b0));
    sb_q.push_back(mk(4'b0010, 5'b00010, 3'd1, 1'b0));
    issue(2'b11, 4'b0000, 1'b0, 3'd3, "stm3");
    tick();
    #5;
    rst_n = 1'b0;
    #1;
    chk("rst2_vld", out_valid, 0);
    chk("rst2_bundle", bundle, 0);
    chk("rst2_sb", sb_q.size(), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst2_idle_rdy", in_ready, 1);
    chk("rst2_no_beat2", out_valid, 0);

    tick();
    chk("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
